// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
//   Controller that feeds a 4-bit combinational ALU. It accepts register-based
//   instructions over a valid/ready port, reads the operands from a small
//   internal register file, drives A/B/op to the ALU and, one cycle later,
//   captures the ALU result, writes it back and reports completion.
//
//   Sequence: IDLE --accept--> ISSUE --capture--> WRBACK --> IDLE
//   (one instruction every 3 cycles; the result appears with res_valid two
//   cycles after the accepting edge).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/ready    instruction handshake
//   instr_op             ALU opcode
//   instr_src_a/src_b    operand register indices
//   instr_dst            destination register index
//   ld_en/addr/data      direct register load (any state)
//   rd_addr, rd_data     combinational register readback
//   alu_a, alu_b, alu_op operands/opcode to the ALU (hold outside ISSUE)
//   alu_result           combinational ALU output
//   res_valid            one-cycle pulse on writeback
//   res_data, res_dst    last written-back value and its destination
//   busy                 FSM is not in IDLE
//   done_count           completed instructions, saturating
//
// Optional feature (macro ALU_ISSUER_FLAGS_EN)
//   res_zero, res_carry  flags registered together with res_data
// ---------------------------------------------------------------------------
module alu_issuer #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_src_a,
  input  logic [REG_AW-1:0] instr_src_b,
  input  logic [REG_AW-1:0] instr_dst,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_dst,
`ifdef ALU_ISSUER_FLAGS_EN
  output logic              res_zero,
  output logic              res_carry,
`endif
  output logic              busy,
  output logic [CNT_W-1:0]  done_count
);

  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [1:0] {IDLE, ISSUE, WRBACK} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];
  logic [REG_AW-1:0] dst;
  logic              wb_en;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign wb_en       = (state == ISSUE);
  assign rd_data     = regs[rd_addr];

  // Register file. The ISSUE-edge writeback takes priority over a direct
  // load to the same address; loads to other addresses proceed in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && dst == REG_AW'(i))
          regs[i] <= alu_result;
        else if (ld_en && ld_addr == REG_AW'(i))
          regs[i] <= ld_data;
      end
    end
  end

`ifdef ALU_ISSUER_FLAGS_EN
  // Carry/borrow derived from the latched operands, one bit wider than data.
  logic [DATA_W:0] sum_ext;
  logic            carry_calc;

  assign sum_ext = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    carry_calc = 1'b0;
    case (alu_op)
      3'b000:  carry_calc = sum_ext[DATA_W];
      3'b001:  carry_calc = (alu_a < alu_b);
      default: carry_calc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
    end else if (wb_en) begin
      res_zero  <= (alu_result == '0);
      res_carry <= carry_calc;
    end
  end
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dst        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_dst    <= '0;
      done_count <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Operand snapshot: a load landing on this same edge is not seen.
          if (instr_valid) begin
            alu_a  <= regs[instr_src_a];
            alu_b  <= regs[instr_src_b];
            alu_op <= instr_op;
            dst    <= instr_dst;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_data  <= alu_result;
          res_dst   <= dst;
          res_valid <= 1'b1;
          // Counter updates on entry to WRBACK so it is current while
          // res_valid is high.
          if (done_count != {CNT_W{1'b1}})
            done_count <= done_count + 1'b1;
          state <= WRBACK;
        end
        WRBACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
module tb_alu_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_src_a, instr_src_b, instr_dst;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       res_valid;
  logic [3:0] res_data;
  logic [1:0] res_dst;
  logic       busy;
  logic [7:0] done_count;
`ifdef ALU_ISSUER_FLAGS_EN
  logic       res_zero, res_carry;
`endif

  alu_issuer #(.DATA_W(4), .REG_AW(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_src_a(instr_src_a),
    .instr_src_b(instr_src_b), .instr_dst(instr_dst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst),
`ifdef ALU_ISSUER_FLAGS_EN
    .res_zero(res_zero), .res_carry(res_carry),
`endif
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] data;
    logic [1:0] dst;
    logic       zero;
    logic       carry;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model [4];
  int         dcount = 0;

  // Reference behaviour of the team ALU (also used as the ALU attached to the DUT).
  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b101:  return ~b;
      3'b110:  return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", res_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_dst", res_dst, e.dst);
`ifdef ALU_ISSUER_FLAGS_EN
        check("res_zero", res_zero, e.zero);
        check("res_carry", res_carry, e.carry);
`endif
        $display("[TB] result dst=r%0d data=%h (expected r%0d %h)", res_dst, res_data, e.dst, e.data);
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model[a] = d;
    @(negedge clk);
    $display("[TB] load r%0d=%h", a, d);
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [3:0] exp);
    rd_addr = a; #1;
    check(tag, rd_data, exp);
    check({tag, "_model"}, rd_data, model[a]);
  endtask

  task automatic check_count();
    @(negedge clk);
    check("done_count", done_count, dcount);
  endtask

  // Issue one instruction; optionally keep instr_valid high afterwards and
  // optionally fire a direct load on the writeback edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sbx,
                       input logic [1:0] d, input bit hold, input bit b2b,
                       input bit do_ld, input logic [1:0] la, input logic [3:0] ldd);
    exp_t e;
    logic [4:0] s;
    int n;
    e.data  = ref_alu(op, model[sa], model[sbx]);
    e.dst   = d;
    e.zero  = (e.data == 4'h0);
    s       = {1'b0, model[sa]} + {1'b0, model[sbx]};
    e.carry = (op == 3'b000) ? s[4] : (op == 3'b001) ? (model[sa] < model[sbx]) : 1'b0;
    sb.push_back(e);
    instr_valid = 1'b1; instr_op = op; instr_src_a = sa; instr_src_b = sbx; instr_dst = d;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) check("accept_timeout", instr_ready, 1);
    @(posedge clk); #1;
    if (b2b) check("throughput", cyc - last_acc, 3);
    last_acc = cyc;
    if (!hold) instr_valid = 1'b0;
    if (do_ld) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    model[d] = e.data;
    if (do_ld && la != d) model[la] = ldd;
    if (dcount < 255) dcount++;
    @(negedge clk);
    check("issue_ready", instr_ready, 0);
    check("issue_res_valid", res_valid, 0);
    check("issue_busy", busy, 1);
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(negedge clk);
    check("wrback_ready", instr_ready, 0);
    check("wrback_res_valid", res_valid, 1);
    $display("[TB] issue op=%b a=r%0d b=r%0d dst=r%0d expect=%h", op, sa, sbx, d, e.data);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_src_a = '0; instr_src_b = '0;
    instr_dst = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) model[i] = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done_count, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_dst", res_dst, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 4'h0);

    // 9 + 8 wraps to 1 with carry
    load(2'd1, 4'h9); load(2'd2, 4'h8);
    issue(3'b000, 2'd1, 2'd2, 2'd3, 0, 0, 0, 2'd0, 4'h0);
    check_reg("add_r3", 2'd3, 4'h1);
    check_count();

    // 3 - 5 = E with borrow, src == dst
    load(2'd0, 4'h3); load(2'd1, 4'h5);
    issue(3'b001, 2'd0, 2'd1, 2'd0, 0, 0, 0, 2'd0, 4'h0);
    check_reg("sub_r0", 2'd0, 4'hE);

    // Back-to-back with instr_valid held
    load(2'd1, 4'hC); load(2'd2, 4'hA);
    issue(3'b010, 2'd1, 2'd2, 2'd0, 1, 0, 0, 2'd0, 4'h0);
    issue(3'b110, 2'd1, 2'd2, 2'd3, 1, 1, 0, 2'd0, 4'h0);
    issue(3'b111, 2'd1, 2'd2, 2'd0, 1, 1, 0, 2'd0, 4'h0);
    instr_valid = 1'b0;
    check_reg("b2b_r0", 2'd0, 4'h9);
    check_reg("b2b_r3", 2'd3, 4'h6);

    // Collisions on the writeback edge
    load(2'd0, 4'h1); load(2'd1, 4'h1);
    issue(3'b000, 2'd0, 2'd1, 2'd3, 0, 0, 1, 2'd3, 4'hF);
    check_reg("coll_same", 2'd3, 4'h2);
    issue(3'b000, 2'd0, 2'd1, 2'd3, 0, 0, 1, 2'd2, 4'h7);
    check_reg("coll_diff_r2", 2'd2, 4'h7);
    check_reg("coll_diff_r3", 2'd3, 4'h2);
    // Load to a source after acceptance leaves the in-flight operand alone
    issue(3'b000, 2'd0, 2'd1, 2'd2, 0, 0, 1, 2'd0, 4'hF);
    check_reg("snap_r2", 2'd2, 4'h2);
    check_reg("snap_r0", 2'd0, 4'hF);
    check_count();

    // Reset during ISSUE aborts the instruction
    instr_valid = 1'b1; instr_op = 3'b000; instr_src_a = 2'd0; instr_src_b = 2'd1; instr_dst = 2'd3;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("abort_in_issue", busy, 1);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 4'h0;
    dcount = 0;
    @(negedge clk);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done_count, 0);
    for (int i = 0; i < 4; i++) check_reg("abort_reg", 2'(i), 4'h0);
    @(negedge clk);
    check("abort_res_valid2", res_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", instr_ready, 1);
    check("abort_res_valid3", res_valid, 0);
    $display("[TB] reset during ISSUE done");

    // Saturation: 258 instructions of NOT A on r1 = 0
    load(2'd1, 4'h0);
    for (int k = 0; k < 258; k++) begin
      issue(3'b100, 2'd1, 2'd1, 2'd2, 0, 0, 0, 2'd0, 4'h0);
      check_count();
    end
    check("sat_value", done_count, 8'hFF);
    check_reg("not_a_r2", 2'd2, 4'hF);

    // XNOR with a == b
    load(2'd0, 4'h6);
    issue(3'b111, 2'd0, 2'd0, 2'd3, 0, 0, 0, 2'd0, 4'h0);
    check_reg("xnor_r3", 2'd3, 4'hF);
    check_count();

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator/controller for the team's 4-bit combinational ALU (ops 000 add, 001 sub, 010 and, 011 or, 100 not A, 101 not B, 110 xor, 111 xnor).
- Accepts register-based instructions over a valid/ready port and reads operands from a small internal register file.
- Drives A/B/op to the ALU and captures the ALU result one cycle later. Writes the result back and reports completion.

Parameters:
- DATA_W, 4, operand/result width; must equal the ALU width.
- REG_AW, 2, register file address width; register count is 2**REG_AW.
- CNT_W, 8, width of the completed-instruction counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  issuer can accept an instruction.
- instr_op  input  3  ALU opcode.
- instr_src_a  input  REG_AW  register index for operand A.
- instr_src_b  input  REG_AW  register index for operand B.
- instr_dst  input  REG_AW  destination register index.
- ld_en  input  1  direct register load strobe.
- ld_addr  input  REG_AW  load address.
- ld_data  input  DATA_W  load data.
- rd_addr  input  REG_AW  readback address.
- rd_data  output  DATA_W  combinational readback of the register at rd_addr.
- alu_a  output  DATA_W  operand A to the ALU.
- alu_b  output  DATA_W  operand B to the ALU.
- alu_op  output  3  opcode to the ALU.
- alu_result  input  DATA_W  ALU output (combinational, same cycle).
- res_valid  output  1  one-cycle pulse when a result is written back.
- res_data  output  DATA_W  written-back value; held until the next res_valid.
- res_dst  output  REG_AW  destination of the last result.
- busy  output  1  high whenever the FSM is not in IDLE.
- done_count  output  CNT_W  number of completed instructions; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All registers, alu_a, alu_b, alu_op, res_data, res_dst and done_count are cleared to 0.
  - res_valid=0, busy=0, instr_ready=1 after release.
- FSM states: IDLE, ISSUE, WRBACK.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register the decoded fields, latch alu_a=reg[src_a], alu_b=reg[src_b], alu_op=instr_op, then go to ISSUE.
- ISSUE:
  - instr_ready=0.
  - Operands are stable on alu_a/alu_b/alu_op.
  - At this edge, capture alu_result into reg[dst], res_data and res_dst, then go to WRBACK.
- WRBACK:
  - res_valid=1 for exactly this cycle.
  - Increment done_count, saturating.
  - instr_ready=0; return to IDLE.
- Latency: handshake at edge N; result visible in the register file and on res_data with res_valid=1 in cycle N+2.
- Throughput: one instruction per 3 cycles.
- alu_a/alu_b/alu_op hold their last values outside ISSUE; they are not cleared.
- Operand read is a snapshot at acceptance. src==dst is legal (e.g. r0=r0+r0).
- Arithmetic width: the result is DATA_W bits and wraps modulo 2**DATA_W, exactly as the ALU delivers it.
- Load/writeback collision: if ld_en coincides with the ISSUE-edge writeback to the same address, the writeback wins and the load is dropped. Different addresses: both writes happen.
- ld_en is accepted in any state. A load to a source register after acceptance does not affect the in-flight operands.
- instr_valid while not ready: ignored. The source must hold the instruction until the handshake.
- rst_n asserted mid-operation: the in-flight instruction is aborted, there is no res_valid, and all state is cleared.

Optional Feature:
- Macro: ALU_ISSUER_FLAGS_EN.
- When defined, add outputs res_zero(1) and res_carry(1), registered with res_data:
  - res_zero = (captured result == 0).
  - res_carry = carry-out of A+B for op 000; borrow (A<B unsigned) for op 001; 0 for all other ops.
  - The carry is computed internally from the latched operands at DATA_W+1 bits.
  - Both flags reset to 0.
- When not defined, these ports and their logic are absent.

Test Plan:
- Reset, then load r1=4'h9, r2=4'h8; issue op=000, a=r1, b=r2, dst=r3 -> res_valid at handshake+2, res_data=4'h1, rd_data(r3)=4'h1, done_count=1 (FLAGS_EN: res_carry=1, res_zero=0).
- Load r0=4'h3, r1=4'h5; issue op=001, a=r0, b=r1, dst=r0 -> r0=4'hE (FLAGS_EN: carry/borrow=1).
- Back-to-back: hold instr_valid for ops 010, 110 and 111 on r1=4'hC, r2=4'hA -> instr_ready low for 2 cycles after each accept; results 4'h8, 4'h6, 4'h9 in order.
- Collision: ld_en to r3 with 4'hF on the same edge as the writeback to r3 of value 4'h2 -> r3=4'h2. A load to r2 on that edge succeeds.
- Assert rst_n low during ISSUE -> no res_valid, all registers 0, done_count=0, instr_ready=1 after release.
- Issue 255 plus 3 instructions with CNT_W=8 -> done_count saturates at 8'hFF. Op 100 on r1=4'h0 gives 4'hF (FLAGS_EN: res_zero=0); op 111 with a=b gives 4'hF.
